// File: rtl/cp0_regfile.sv
// -----------------------------------------------------------------------------
// cp0_regfile -- MIPS-style coprocessor-0 register file
//
// Holds Index, EntryLo0/1, BadVAddr, Count, EntryHi, Compare, Status, Cause
// and EPC. Updates come from four sources, applied in priority order per
// field: writeback exception, ERET, TLBR/TLBP, then MTC0.
//
// Optional feature macro: CP0_TIMER_INT_EN
//   defined   -> Count/Compare timer with TI interrupt routed to IP[7]
//   undefined -> Count/Compare read 0 and ignore writes; TI is always 0
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   wb_ex, ex_type, wb_bd,         exception report from writeback
//   wb_pc, wb_badvaddr, wb_eret
//   mtc0_we, c0_addr, c0_wdata     register write ({rd,sel} address)
//   ext_int_in                     level-sensitive hardware interrupts
//   is_TLBR, TLB_rdata             TLB read result load
//   is_TLBP, index_write_p,        TLB probe result load
//   index_write_index
//   c0_rdata                       combinational read of c0_addr
//   ws_epc                         EPC value
//   has_int                        pending, enabled interrupt
//   cp0_index/entryhi/entrylo0/1   register values for the TLB
// -----------------------------------------------------------------------------
module cp0_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_ex,
  input  logic [4:0]  ex_type,
  input  logic        wb_bd,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_badvaddr,
  input  logic        wb_eret,
  input  logic        mtc0_we,
  input  logic [7:0]  c0_addr,
  input  logic [31:0] c0_wdata,
  input  logic [5:0]  ext_int_in,
  input  logic        is_TLBR,
  input  logic [77:0] TLB_rdata,
  input  logic        is_TLBP,
  input  logic        index_write_p,
  input  logic [3:0]  index_write_index,
  output logic [31:0] c0_rdata,
  output logic [31:0] ws_epc,
  output logic        has_int,
  output logic [31:0] cp0_index,
  output logic [31:0] cp0_entryhi,
  output logic [31:0] cp0_entrylo0,
  output logic [31:0] cp0_entrylo1
);

  localparam logic [7:0] ADDR_INDEX    = 8'h00;
  localparam logic [7:0] ADDR_ENTRYLO0 = 8'h10;
  localparam logic [7:0] ADDR_ENTRYLO1 = 8'h18;
  localparam logic [7:0] ADDR_BADVADDR = 8'h40;
  localparam logic [7:0] ADDR_COUNT    = 8'h48;
  localparam logic [7:0] ADDR_ENTRYHI  = 8'h50;
  localparam logic [7:0] ADDR_COMPARE  = 8'h58;
  localparam logic [7:0] ADDR_STATUS   = 8'h60;
  localparam logic [7:0] ADDR_CAUSE    = 8'h68;
  localparam logic [7:0] ADDR_EPC      = 8'h70;

  // MTC0 write strobes
  logic we_index, we_lo0, we_lo1, we_hi, we_status, we_cause, we_epc;
  assign we_index  = mtc0_we && (c0_addr == ADDR_INDEX);
  assign we_lo0    = mtc0_we && (c0_addr == ADDR_ENTRYLO0);
  assign we_lo1    = mtc0_we && (c0_addr == ADDR_ENTRYLO1);
  assign we_hi     = mtc0_we && (c0_addr == ADDR_ENTRYHI);
  assign we_status = mtc0_we && (c0_addr == ADDR_STATUS);
  assign we_cause  = mtc0_we && (c0_addr == ADDR_CAUSE);
  assign we_epc    = mtc0_we && (c0_addr == ADDR_EPC);

  // Only the writable fields are stored; the rest are rebuilt as zeros.
  logic        index_p_q,   index_p_d;
  logic [3:0]  index_q,     index_d;
  logic [25:0] lo0_q,       lo0_d;
  logic [25:0] lo1_q,       lo1_d;
  logic [31:0] badvaddr_q,  badvaddr_d;
  logic [18:0] vpn2_q,      vpn2_d;
  logic [7:0]  asid_q,      asid_d;
  logic [7:0]  im_q,        im_d;
  logic        exl_q,       exl_d;
  logic        ie_q,        ie_d;
  logic        bd_q,        bd_d;
  logic [5:0]  ip_hw_q,     ip_hw_d;
  logic [1:0]  ip_sw_q,     ip_sw_d;
  logic [4:0]  exc_q,       exc_d;
  logic [31:0] epc_q,       epc_d;

  // Timer view used by the read mux and interrupt logic
  logic [31:0] count_v;
  logic [31:0] compare_v;
  logic        ti_v;

  // TLB_rdata unpacking; g lands in bit 0 of both EntryLo images
  logic        tlb_g;
  assign tlb_g = TLB_rdata[50];

  logic ex_badv, ex_tlb;
  assign ex_badv = (ex_type >= 5'h01) && (ex_type <= 5'h05);
  assign ex_tlb  = (ex_type >= 5'h01) && (ex_type <= 5'h03);

  // ---------------------------------------------------------------------------
  // Next-state: lowest priority first so higher-priority sources overwrite
  // only the fields they actually touch.
  // ---------------------------------------------------------------------------
  always_comb begin
    index_p_d  = index_p_q;
    index_d    = index_q;
    lo0_d      = lo0_q;
    lo1_d      = lo1_q;
    badvaddr_d = badvaddr_q;
    vpn2_d     = vpn2_q;
    asid_d     = asid_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_hw_d    = ext_int_in;
    ip_sw_d    = ip_sw_q;
    exc_d      = exc_q;
    epc_d      = epc_q;

    // MTC0 (lowest)
    if (we_index) index_d = c0_wdata[3:0];
    if (we_lo0)   lo0_d   = c0_wdata[25:0];
    if (we_lo1)   lo1_d   = c0_wdata[25:0];
    if (we_hi) begin
      vpn2_d = c0_wdata[31:13];
      asid_d = c0_wdata[7:0];
    end
    if (we_status) begin
      im_d  = c0_wdata[15:8];
      exl_d = c0_wdata[1];
      ie_d  = c0_wdata[0];
    end
    if (we_cause) ip_sw_d = c0_wdata[9:8];
    if (we_epc)   epc_d   = c0_wdata;

    // TLB instructions
    if (is_TLBR) begin
      vpn2_d = TLB_rdata[77:59];
      asid_d = TLB_rdata[58:51];
      lo0_d  = {TLB_rdata[49:25], tlb_g};
      lo1_d  = {TLB_rdata[24:0],  tlb_g};
    end
    if (is_TLBP) begin
      index_p_d = index_write_p;
      index_d   = index_write_index;
    end

    // ERET
    if (wb_eret) exl_d = 1'b0;

    // Exception (highest); EPC/BD frozen while already in exception level
    if (wb_ex) begin
      exl_d = 1'b1;
      exc_d = ex_type;
      if (!exl_q) begin
        epc_d = wb_bd ? (wb_pc - 32'd4) : wb_pc;
        bd_d  = wb_bd;
      end
      if (ex_badv) badvaddr_d = wb_badvaddr;
      if (ex_tlb)  vpn2_d     = wb_badvaddr[31:13];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index_p_q  <= 1'b0;
      index_q    <= '0;
      lo0_q      <= '0;
      lo1_q      <= '0;
      badvaddr_q <= '0;
      vpn2_q     <= '0;
      asid_q     <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      exc_q      <= '0;
      epc_q      <= '0;
    end else begin
      index_p_q  <= index_p_d;
      index_q    <= index_d;
      lo0_q      <= lo0_d;
      lo1_q      <= lo1_d;
      badvaddr_q <= badvaddr_d;
      vpn2_q     <= vpn2_d;
      asid_q     <= asid_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exc_q      <= exc_d;
      epc_q      <= epc_d;
    end
  end

`ifdef CP0_TIMER_INT_EN
  // ---------------------------------------------------------------------------
  // Timer: Count advances every other cycle (on tick=1). A match raises TI,
  // which stays set until software rewrites Compare.
  // ---------------------------------------------------------------------------
  logic        we_count, we_compare;
  logic        tick_q,    tick_d;
  logic [31:0] count_q,   count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q,      ti_d;

  assign we_count   = mtc0_we && (c0_addr == ADDR_COUNT);
  assign we_compare = mtc0_we && (c0_addr == ADDR_COMPARE);

  always_comb begin
    tick_d    = ~tick_q;
    count_d   = tick_q ? (count_q + 32'd1) : count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (we_count) begin
      count_d = c0_wdata;
      tick_d  = 1'b0;
    end
    if (we_compare) begin
      compare_d = c0_wdata;
      ti_d      = 1'b0;
    end else if (count_q == compare_q) begin
      ti_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q    <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_v   = count_q;
  assign compare_v = compare_q;
  assign ti_v      = ti_q;
`else
  assign count_v   = 32'd0;
  assign compare_v = 32'd0;
  assign ti_v      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Register images
  // ---------------------------------------------------------------------------
  logic [7:0]  ip_all;     // Cause.IP[15:8], TI folded into IP[15]
  logic [31:0] status_img, cause_img;

  assign ip_all     = {ip_hw_q[5] | ti_v, ip_hw_q[4:0], ip_sw_q};
  assign status_img = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_img  = {bd_q, ti_v, 14'b0, ip_all, 1'b0, exc_q, 2'b0};

  assign cp0_index    = {index_p_q, 27'b0, index_q};
  assign cp0_entryhi  = {vpn2_q, 5'b0, asid_q};
  assign cp0_entrylo0 = {6'b0, lo0_q};
  assign cp0_entrylo1 = {6'b0, lo1_q};
  assign ws_epc       = epc_q;

  assign has_int = (|(ip_all & im_q)) & ie_q & ~exl_q;

  always_comb begin
    c0_rdata = 32'd0;
    case (c0_addr)
      ADDR_INDEX:    c0_rdata = cp0_index;
      ADDR_ENTRYLO0: c0_rdata = cp0_entrylo0;
      ADDR_ENTRYLO1: c0_rdata = cp0_entrylo1;
      ADDR_BADVADDR: c0_rdata = badvaddr_q;
      ADDR_COUNT:    c0_rdata = count_v;
      ADDR_ENTRYHI:  c0_rdata = cp0_entryhi;
      ADDR_COMPARE:  c0_rdata = compare_v;
      ADDR_STATUS:   c0_rdata = status_img;
      ADDR_CAUSE:    c0_rdata = cause_img;
      ADDR_EPC:      c0_rdata = epc_q;
      default:       c0_rdata = 32'd0;
    endcase
  end

endmodule
